fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage upstream of instruction_memory: owns the program counter, drives the
//  word address into the memory, and captures the combinational instruction word into an IF/ID
//  register with a valid/ready handshake toward decode. Supports redirect (branch/jump) with
//  flush, decode back-pressure, and a HALT state entered when a halt word is fetched.
// PARAMETERS
//  RESET_PC   32'd0           PC value loaded on reset (word index)
//  HALT_WORD  32'hFFFF_FFFF   instruction encoding that stops fetch
//  NOP_WORD   32'h0000_0000   value driven on if_ins while the stage is empty after reset/flush
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous active-low reset
//  imem_addr       out  32  word address to instruction_memory (= pc register, no logic after flop)
//  imem_ins        in   32  instruction word returned combinationally by instruction_memory
//  redirect_valid  in   1   taken branch/jump from execute; loads redirect_pc
//  redirect_pc     in   32  redirect target (word index)
//  id_ready        in   1   decode accepts if_ins this cycle
//  if_valid        out  1   IF/ID register holds a valid instruction
//  if_ins          out  32  fetched instruction
//  if_pc           out  32  word address if_ins was fetched from
//  halted          out  1   high while state == HALTED
//  fetch_count     out  32  number of instructions captured into IF/ID since reset
// BEHAVIOUR
//  - PC counts words: sequential increment is +1, not +4. pc+1 wraps modulo 2^32; the memory
//    decodes addr[9:0], so 1023 -> 1024 aliases word 0. No wrap detection.
//  - Reset (async, rst_n=0): pc=RESET_PC, if_valid=0, if_ins=NOP_WORD, if_pc=0, halted=0,
//    fetch_count=0, state=IDLE. Reset asserted mid-operation discards everything immediately.
//  - capture = (state==RUN) && !redirect_valid && (!if_valid || id_ready).
//    On capture: if_ins<=imem_ins, if_pc<=pc, if_valid<=1, fetch_count<=fetch_count+1,
//    pc<=pc+1 unless imem_ins==HALT_WORD (then pc holds at the halt word's address).
//  - Consume without capture: if id_ready && if_valid && !capture -> if_valid<=0.
//  - No capture and no consume: IF/ID and pc hold (back-pressure).
//  - Latency: instruction at address A is visible on if_ins one cycle after pc==A with capture.
//    Throughput: 1 instr/cycle while id_ready=1.
//  - FSM:
//    IDLE    one cycle after reset release, no capture -> RUN. redirect here: pc<=redirect_pc,
//            -> RUN.
//    RUN     capture of HALT_WORD -> HALTED (the halt word itself is delivered to decode).
//    HALTED  pc frozen, no captures; pending if_valid still drains via id_ready.
//            redirect -> RUN.
//  - Redirect (any state): pc<=redirect_pc, if_valid<=0, if_ins<=NOP_WORD (flush), count
//    unchanged. Redirect has priority over capture and over id_ready in the same cycle.
//  - halted is a registered decode of state; imem_addr is always pc, even in HALTED/IDLE.
// STRUCTURE
//  - Shared package/include fetch_defs: state encoding (IDLE=2'd0, RUN=2'd1, HALTED=2'd2),
//    HALT_WORD and NOP_WORD constants, also used by decode.
//  - Single module; no sub-module needed (pc register, IF/ID register, 2-bit FSM, counter).
// TESTING
//  1 Reset with mem[0..3]=I0..I3, id_ready=1 -> IDLE 1 cycle; then if_ins=I0,I1,I2 on
//    consecutive cycles, if_pc=0,1,2; fetch_count=3.
//  2 id_ready=0 for 3 cycles while if_valid=1 -> if_ins/if_pc/pc/fetch_count all hold;
//    on release, next instruction follows with no loss or duplication.
//  3 redirect_valid=1, redirect_pc=100 with id_ready=1 in the same cycle -> next cycle
//    if_valid=0, if_ins=NOP_WORD, pc=100; following cycle if_ins=mem[100], if_pc=100.
//  4 mem[5]=32'hFFFF_FFFF -> HALT word delivered with if_pc=5, halted=1, pc stays 5,
//    fetch_count frozen; redirect to 0 -> halted=0, fetch resumes from 0.
//  5 Set pc to 1023 via redirect -> fetches 1023 then imem_addr=1024, and memory returns
//    mem[0]; if_pc=1024. Redirect 32'hFFFF_FFFF -> next pc=0.
//  6 Assert rst_n=0 asynchronously mid-stream (between clock edges) -> if_valid=0, pc=0,
//    fetch_count=0 immediately; normal fetch resumes after release + 1 IDLE cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding plus the special
// instruction encodings that fetch and decode both need to recognise.
package fetch_unit_pkg;

  // Fetch FSM states; the encoding is visible to decode, so keep it fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC  = 32'd0;
  localparam logic [31:0] FETCH_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] FETCH_NOP_WORD  = 32'h0000_0000;

  // True when an instruction word is the encoding that stops fetch.
  function automatic logic is_halt_word(input logic [31:0] ins,
                                        input logic [31:0] halt_word);
    return (ins == halt_word);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the word-indexed program counter, drives
// the instruction memory address, and captures the returned word into an
// IF/ID register with a valid/ready handshake toward decode. Supports
// redirect with flush, back-pressure, and a HALTED state on a halt word.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0] HALT_WORD = FETCH_HALT_WORD,
  parameter logic [31:0] NOP_WORD  = FETCH_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ins,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  ins_q, ins_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  count_q, count_d;
  logic         halted_q;
  logic         capture;
  logic         fetched_halt;

  // Capture happens only while running, never in a redirect cycle, and only
  // when the IF/ID slot is empty or being drained by decode this cycle.
  assign capture      = (state_q == ST_RUN) && !redirect_valid && (!valid_q || id_ready);
  assign fetched_halt = is_halt_word(imem_ins, HALT_WORD);

  // Next-state logic for the FSM, program counter, IF/ID register and counter.
  // Redirect wins over everything else; otherwise capture, then consume.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ins_d   = ins_q;
    if_pc_d = if_pc_q;
    count_d = count_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      ins_d   = NOP_WORD;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_RUN;
        ST_RUN:    if (capture && fetched_halt) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase

      if (capture) begin
        ins_d   = imem_ins;
        if_pc_d = pc_q;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
        if (!fetched_halt) begin
          pc_d = pc_q + 32'd1;
        end
      end else if (id_ready && valid_q) begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any in-flight instruction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      ins_q    <= NOP_WORD;
      if_pc_q  <= 32'd0;
      count_q  <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      ins_q    <= ins_d;
      if_pc_q  <= if_pc_d;
      count_q  <= count_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_ins      = ins_q;
  assign if_pc       = if_pc_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written
// reset/halt sequences, and a randomized run against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk;
  logic        rstN;
  logic [31:0] imemAddr;
  logic [31:0] imemIns;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        idReady;
  logic        ifValid;
  logic [31:0] ifIns;
  logic [31:0] ifPc;
  logic        halted;
  logic [31:0] fetchCount;

  logic [31:0] mem [1024];

  int tbTests;
  int tbFails;

  // Behavioural model state: mode 0 = waiting after reset, 1 = fetching, 2 = stopped
  int          mMode;
  logic [31:0] mPc;
  logic        mValid;
  logic [31:0] mIns;
  logic [31:0] mIfPc;
  logic [31:0] mCount;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        eValid;
    logic [31:0] eIns;
    logic [31:0] eIfPc;
    logic [31:0] eAddr;
    logic        eHalted;
    logic [31:0] eCount;
  } vec_t;

  vec_t vecs [22];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rstN),
    .imem_addr      (imemAddr),
    .imem_ins       (imemIns),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .id_ready       (idReady),
    .if_valid       (ifValid),
    .if_ins         (ifIns),
    .if_pc          (ifPc),
    .halted         (halted),
    .fetch_count    (fetchCount)
  );

  // The memory decodes only the low ten address bits and answers combinationally
  assign imemIns = mem[imemAddr[9:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] iw(input int a);
    return 32'h1000_0000 | a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tbTests++;
    if (act !== exp) begin
      tbFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mMode  = 0;
    mPc    = 32'd0;
    mValid = 1'b0;
    mIns   = NOP;
    mIfPc  = 32'd0;
    mCount = 32'd0;
  endtask

  // One clock of the fetch rules: flush on redirect, else start up, capture, or drain
  task automatic modelStep(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] word;
    word = mem[mPc % 1024];
    if (rv) begin
      mPc    = rpc;
      mValid = 1'b0;
      mIns   = NOP;
      mMode  = 1;
    end else if (mMode == 0) begin
      mMode = 1;
    end else if (mMode == 1 && (!mValid || rdy)) begin
      mIns   = word;
      mIfPc  = mPc;
      mValid = 1'b1;
      mCount = mCount + 1;
      if (word == HALT) mMode = 2;
      else              mPc = mPc + 1;
    end else if (rdy && mValid) begin
      mValid = 1'b0;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " if_valid"}, {31'd0, ifValid}, {31'd0, mValid});
    checkOutput({tag, " if_ins"}, ifIns, mIns);
    checkOutput({tag, " if_pc"}, ifPc, mIfPc);
    checkOutput({tag, " imem_addr"}, imemAddr, mPc);
    checkOutput({tag, " halted"}, {31'd0, halted}, {31'd0, (mMode == 2)});
    checkOutput({tag, " fetch_count"}, fetchCount, mCount);
  endtask

  // Drive one cycle of inputs, advance the model, and sample just after the edge
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirectValid = rv;
    redirectPc    = rpc;
    idReady       = rdy;
    modelStep(rv, rpc, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN          = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'd0;
    idReady       = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic setVec(input int i, input logic rv, input logic [31:0] rpc, input logic rdy,
                        input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                        input logic [31:0] ea, input logic eh, input logic [31:0] ec);
    vecs[i].rv = rv; vecs[i].rpc = rpc; vecs[i].rdy = rdy;
    vecs[i].eValid = ev; vecs[i].eIns = ei; vecs[i].eIfPc = ep;
    vecs[i].eAddr = ea; vecs[i].eHalted = eh; vecs[i].eCount = ec;
  endtask

  initial begin
    string tag;
    int    r;
    logic  rv;
    logic  rdy;
    logic [31:0] rpc;
    tbTests = 0;
    tbFails = 0;

    for (int i = 0; i < 1024; i++) mem[i] = iw(i);
    mem[5] = HALT;

    // Directed vectors: startup, stall, halt, redirect flush, wrap
    setVec( 0, 0, 0,    1, 0, NOP,      0,    0,    0, 0);
    setVec( 1, 0, 0,    1, 1, iw(0),    0,    1,    0, 1);
    setVec( 2, 0, 0,    1, 1, iw(1),    1,    2,    0, 2);
    setVec( 3, 0, 0,    1, 1, iw(2),    2,    3,    0, 3);
    setVec( 4, 0, 0,    0, 1, iw(2),    2,    3,    0, 3);
    setVec( 5, 0, 0,    0, 1, iw(2),    2,    3,    0, 3);
    setVec( 6, 0, 0,    0, 1, iw(2),    2,    3,    0, 3);
    setVec( 7, 0, 0,    1, 1, iw(3),    3,    4,    0, 4);
    setVec( 8, 0, 0,    1, 1, iw(4),    4,    5,    0, 5);
    setVec( 9, 0, 0,    1, 1, HALT,     5,    5,    1, 6);
    setVec(10, 0, 0,    1, 0, HALT,     5,    5,    1, 6);
    setVec(11, 0, 0,    1, 0, HALT,     5,    5,    1, 6);
    setVec(12, 1, 100,  1, 0, NOP,      5,    100,  0, 6);
    setVec(13, 0, 0,    1, 1, iw(100),  100,  101,  0, 7);
    setVec(14, 1, 100,  1, 0, NOP,      100,  100,  0, 7);
    setVec(15, 0, 0,    1, 1, iw(100),  100,  101,  0, 8);
    setVec(16, 1, 1023, 1, 0, NOP,      100,  1023, 0, 8);
    setVec(17, 0, 0,    1, 1, iw(1023), 1023, 1024, 0, 9);
    setVec(18, 0, 0,    1, 1, iw(0),    1024, 1025, 0, 10);
    setVec(19, 1, HALT, 1, 0, NOP,      1024, HALT, 0, 10);
    setVec(20, 0, 0,    1, 1, iw(1023), HALT, 0,    0, 11);
    setVec(21, 0, 0,    1, 1, iw(0),    0,    1,    0, 12);

    doReset();
    checkOutput("reset if_valid", {31'd0, ifValid}, 32'd0);
    checkOutput("reset if_ins", ifIns, NOP);
    checkOutput("reset if_pc", ifPc, 32'd0);
    checkOutput("reset imem_addr", imemAddr, 32'd0);
    checkOutput("reset halted", {31'd0, halted}, 32'd0);
    checkOutput("reset fetch_count", fetchCount, 32'd0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, " if_valid"}, {31'd0, ifValid}, {31'd0, vecs[i].eValid});
      checkOutput({tag, " if_ins"}, ifIns, vecs[i].eIns);
      checkOutput({tag, " if_pc"}, ifPc, vecs[i].eIfPc);
      checkOutput({tag, " imem_addr"}, imemAddr, vecs[i].eAddr);
      checkOutput({tag, " halted"}, {31'd0, halted}, {31'd0, vecs[i].eHalted});
      checkOutput({tag, " fetch_count"}, fetchCount, vecs[i].eCount);
    end

    // Halt then redirect to zero resumes fetch from the start of memory
    applyStimulus(1'b1, 32'd3, 1'b1);
    checkModel("halt-a");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkModel("halt-b");
    end
    checkOutput("halt held pc", imemAddr, 32'd5);
    checkOutput("halt flag", {31'd0, halted}, 32'd1);
    applyStimulus(1'b1, 32'd0, 1'b0);
    checkModel("resume-a");
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("resume ins", ifIns, iw(0));
    checkOutput("resume pc", ifPc, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkModel("resume-b");

    // Asynchronous reset between clock edges clears state without waiting for a clock
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("async rst if_valid", {31'd0, ifValid}, 32'd0);
    checkOutput("async rst imem_addr", imemAddr, 32'd0);
    checkOutput("async rst fetch_count", fetchCount, 32'd0);
    checkOutput("async rst halted", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    modelReset();
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("post rst idle valid", {31'd0, ifValid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("post rst ins", ifIns, iw(0));
    checkOutput("post rst count", fetchCount, 32'd1);

    // Randomized run with scattered halt words against the model
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT) mem[i] = 32'd7;
    end
    mem[12] = HALT; mem[200] = HALT; mem[511] = HALT; mem[1022] = HALT;
    doReset();
    checkModel("rand-reset");
    for (int c = 0; c < 600; c++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 3);
      case (r)
        0:       rpc = $urandom_range(0, 1023);
        1:       rpc = 32'd1018 + $urandom_range(0, 5);
        2:       rpc = 32'd8 + $urandom_range(0, 4);
        default: rpc = $urandom;
      endcase
      applyStimulus(rv, rpc, rdy);
      checkModel($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tbTests, tbFails);
    $finish;
  end

endmodule
